// File: rtl/led_sequencer_ctrl.sv
// LED bank sequencer: CPU direct value, stepped 8-entry pattern playback and a
// hardware alarm overlay, all behind an Avalon-MM slave with a done interrupt.
module led_sequencer_ctrl #(
    parameter int LED_W      = 10,
    parameter int PERIOD_W   = 24,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             alarm_req,
    input  logic [LED_W-1:0] alarm_pattern,
    output logic [LED_W-1:0] out_port,
    output logic             irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [PERIOD_W-1:0]   timer_q, timer_d;
    logic [LED_W-1:0]      direct_q, direct_d;
    logic                  run_q, run_d;
    logic                  loop_q, loop_d;
    logic                  irq_en_q, irq_en_d;
    logic [DEPTH_LOG2-1:0] last_q, last_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic                  done_q, done_d;
    logic                  start_q, start_d;
    logic                  alarm_q;
    logic [LED_W-1:0]      pat_q [DEPTH];
    logic [LED_W-1:0]      pat_d [DEPTH];
    logic [LED_W-1:0]      out_q, out_d;
    logic                  irq_q, irq_d;

    logic                  wr_en;
    logic                  ctrl_wr;
    logic                  seq_end;
    logic [PERIOD_W-1:0]   eff_m1;
    logic                  unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign ctrl_wr      = wr_en && (address == 4'd1);
    assign unused_wdata = ^writedata;
    // A programmed period of 0 steps every cycle, exactly like 1.
    assign eff_m1       = (period_q == '0) ? '0 : period_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        direct_d = direct_q;
        run_d    = run_q;
        loop_d   = loop_q;
        irq_en_d = irq_en_q;
        last_d   = last_q;
        period_d = period_q;
        done_d   = done_q;
        start_d  = 1'b0;
        pat_d    = pat_q;
        seq_end  = 1'b0;

        if (wr_en) begin
            case (address)
                4'd0: direct_d = writedata[LED_W-1:0];
                4'd1: begin
                    run_d    = writedata[0];
                    loop_d   = writedata[1];
                    irq_en_d = writedata[2];
                    last_d   = writedata[4 +: DEPTH_LOG2];
                    start_d  = writedata[0];
                end
                4'd2: period_d = writedata[PERIOD_W-1:0];
                4'd3: if (writedata[1]) done_d = 1'b0;
                default: begin
                    if (address[3])
                        pat_d[address[DEPTH_LOG2-1:0]] = writedata[LED_W-1:0];
                end
            endcase
        end

        // A start captured last cycle always wins; the alarm only freezes stepping.
        if (start_q) begin
            state_d = S_RUN;
            idx_d   = '0;
            timer_d = '0;
        end else if (state_q == S_RUN) begin
            if (!run_q) begin
                state_d = S_IDLE;
            end else if (!alarm_q) begin
                if (timer_q >= eff_m1) begin
                    timer_d = '0;
                    if (idx_q < last_q) begin
                        idx_d = idx_q + 1'b1;
                    end else if (loop_q) begin
                        idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        seq_end = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end

        if (seq_end) begin
            done_d = 1'b1;
            if (!ctrl_wr)
                run_d = 1'b0;
        end

        out_d = alarm_q ? alarm_pattern
              : (state_d == S_RUN) ? pat_q[idx_d] : direct_q;
        irq_d = done_q & irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            direct_q <= '0;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            last_q   <= '0;
            period_q <= PERIOD_W'(1);
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            alarm_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                pat_q[i] <= '0;
            out_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            direct_q <= direct_d;
            run_q    <= run_d;
            loop_q   <= loop_d;
            irq_en_q <= irq_en_d;
            last_q   <= last_d;
            period_q <= period_d;
            done_q   <= done_d;
            start_q  <= start_d;
            alarm_q  <= alarm_req;
            pat_q    <= pat_d;
            out_q    <= out_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata[LED_W-1:0] = direct_q;
            4'd1: begin
                readdata[0]                = run_q;
                readdata[1]                = loop_q;
                readdata[2]                = irq_en_q;
                readdata[4 +: DEPTH_LOG2]  = last_q;
            end
            4'd2: readdata[PERIOD_W-1:0] = period_q;
            4'd3: begin
                readdata[0]               = (state_q == S_RUN) | start_q;
                readdata[1]               = done_q;
                readdata[2]               = alarm_q;
                readdata[4 +: DEPTH_LOG2] = idx_q;
            end
            default: begin
                if (address[3])
                    readdata[LED_W-1:0] = pat_q[address[DEPTH_LOG2-1:0]];
            end
        endcase
    end

    assign out_port = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Directed plus randomized bench for led_sequencer_ctrl; LED output is checked
// against a timeline model in which the pattern pauses while the alarm is shown.
module tb_led_sequencer_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        alarm_req;
    logic [9:0]  alarm_pattern;
    logic [9:0]  out_port;
    logic        irq;

    led_sequencer_ctrl dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .alarm_req(alarm_req), .alarm_pattern(alarm_pattern),
        .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] m_direct;
    logic [9:0] m_pat [8];
    int         m_period;
    int         m_last;
    bit         m_loop;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset;
        m_direct = '0;
        for (int i = 0; i < 8; i++) m_pat[i] = '0;
        m_period = 1;
        m_last   = 0;
        m_loop   = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick;
        chipselect = 1'b0; write_n = 1'b1;
        case (a)
            4'd0: m_direct = d[9:0];
            4'd1: begin m_loop = d[1]; m_last = int'(d[6:4]); end
            4'd2: m_period = int'(d[23:0]);
            default: if (a[3]) m_pat[a[2:0]] = d[9:0];
        endcase
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] mask,
                      input logic [31:0] want, input string tag);
        address = a;
        #1;
        chk(tag, readdata & mask, want);
    endtask

    // Value the bank shows during the n-th non-alarm cycle after a start.
    function automatic logic [9:0] seq_val(input int n);
        int eff = (m_period == 0) ? 1 : m_period;
        int len = m_last + 1;
        if (!m_loop && n >= len * eff) return m_direct;
        return m_pat[(n / eff) % len];
    endfunction

    task automatic play(input int cycles, input int al_start, input int al_len,
                        input logic [9:0] al_pat, output int n);
        bit         al_s;
        logic [9:0] want;
        n = 0; al_s = 0;
        for (int c = 0; c < cycles; c++) begin
            alarm_req     = (c >= al_start) && (c < al_start + al_len);
            alarm_pattern = al_pat;
            tick;
            if (al_s) want = al_pat;
            else begin want = seq_val(n); n++; end
            al_s = alarm_req;
            chk($sformatf("out_c%0d", c), {22'b0, out_port}, {22'b0, want});
        end
        alarm_req = 1'b0;
    endtask

    initial begin
        int n;
        int per;
        int last;
        int al_start;
        logic [9:0] v0;
        logic [9:0] v1;

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; alarm_req = 1'b0; alarm_pattern = '0;
        model_reset();
        tick; tick; tick;
        reset = 1'b0;
        tick;
        chk("rst_out", {22'b0, out_port}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        for (int a = 0; a < 16; a++)
            rd(4'(a), 32'hFFFF_FFFF, (a == 2) ? 32'd1 : 32'd0, $sformatf("rst_reg%0d", a));

        // Deselected write must not land.
        address = 4'd0; writedata = 32'h155; chipselect = 1'b0; write_n = 1'b0;
        tick;
        write_n = 1'b1;
        rd(4'd0, 32'hFFFF_FFFF, 32'd0, "cs0_direct");
        wr(4'd0, 32'h2AA);
        chk("direct_k", {22'b0, out_port}, 32'd0);
        tick;
        chk("direct_k1", {22'b0, out_port}, 32'h2AA);
        rd(4'd0, 32'hFFFF_FFFF, 32'h2AA, "direct_rd");

        // One-shot 1,2,4 with period 3 and interrupt.
        wr(4'd8, 32'h001); wr(4'd9, 32'h002); wr(4'd10, 32'h004);
        wr(4'd2, 32'd3);
        rd(4'd10, 32'hFFFF_FFFF, 32'h004, "pat2_rd");
        wr(4'd1, 32'h25);
        play(10, 1000, 0, 10'h0, n);
        rd(4'd3, 32'h3, 32'h2, "oneshot_status");
        rd(4'd1, 32'h77, 32'h24, "oneshot_ctrl");
        chk("irq_lag", {31'b0, irq}, 32'd0);
        tick;
        chk("irq_rise", {31'b0, irq}, 32'd1);
        wr(4'd3, 32'h2);
        chk("irq_hold", {31'b0, irq}, 32'd1);
        tick;
        chk("irq_fall", {31'b0, irq}, 32'd0);
        rd(4'd3, 32'h2, 32'h0, "done_clr");

        // Looping playback, then stop.
        wr(4'd1, 32'h23);
        play(20, 1000, 0, 10'h0, n);
        wr(4'd1, 32'h22);
        tick;
        chk("stop_out", {22'b0, out_port}, {22'b0, m_direct});
        rd(4'd3, 32'h3, 32'h0, "stop_status");
        rd(4'd1, 32'h77, 32'h22, "stop_ctrl");

        // Alarm mid-step during a random one-shot.
        for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'($urandom_range(0, 1023)));
        per  = int'($urandom_range(4, 6));
        last = int'($urandom_range(1, 7));
        wr(4'd2, 32'(per));
        wr(4'd1, 32'((last << 4) | 1));
        al_start = int'($urandom_range(per + 1, 2 * per - 1));
        play((last + 1) * per + 8, al_start, 5, 10'h3FF, n);
        rd(4'd3, 32'h3, 32'h2, "alarm_done");
        wr(4'd3, 32'h2);

        // Alarm overlay in IDLE, one-cycle entry and release.
        v0 = 10'($urandom_range(0, 1023));
        alarm_pattern = v0; alarm_req = 1'b1;
        tick;
        chk("al_idle_k", {22'b0, out_port}, {22'b0, m_direct});
        rd(4'd3, 32'h4, 32'h4, "al_active");
        tick;
        chk("al_idle_k1", {22'b0, out_port}, {22'b0, v0});
        alarm_req = 1'b0;
        tick;
        chk("al_rel_k", {22'b0, out_port}, {22'b0, v0});
        tick;
        chk("al_rel_k1", {22'b0, out_port}, {22'b0, m_direct});
        rd(4'd3, 32'h4, 32'h0, "al_inactive");

        // Period 0 behaves as 1: done after one step.
        wr(4'd0, 32'($urandom_range(0, 1023)));
        wr(4'd8, 32'($urandom_range(0, 1023)));
        wr(4'd2, 32'd0);
        wr(4'd1, 32'h01);
        play(2, 1000, 0, 10'h0, n);
        rd(4'd3, 32'h3, 32'h2, "p0_done");
        wr(4'd3, 32'h2);

        // Software clear coinciding with the done set: set wins.
        wr(4'd1, 32'h01);
        tick;
        wr(4'd3, 32'h2);
        chk("coll_out", {22'b0, out_port}, {22'b0, m_direct});
        rd(4'd3, 32'h2, 32'h2, "coll_done");
        wr(4'd3, 32'h2);

        // Mid-step PERIOD shrink advances on the following cycle.
        v0 = 10'($urandom_range(0, 1023));
        v1 = ~v0;
        wr(4'd8, 32'(v0)); wr(4'd9, 32'(v1));
        wr(4'd2, 32'd5);
        wr(4'd1, 32'h11);
        tick; chk("ps_a0", {22'b0, out_port}, {22'b0, v0});
        tick; chk("ps_a1", {22'b0, out_port}, {22'b0, v0});
        wr(4'd2, 32'd1);
        chk("ps_a2", {22'b0, out_port}, {22'b0, v0});
        tick; chk("ps_b", {22'b0, out_port}, {22'b0, v1});
        tick; chk("ps_end", {22'b0, out_port}, {22'b0, m_direct});

        // Random looping configurations, each a restart of the previous one.
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'($urandom_range(0, 1023)));
            wr(4'd2, 32'($urandom_range(0, 4)));
            wr(4'd1, 32'(($urandom_range(0, 7) << 4) | 3));
            play(40, int'($urandom_range(2, 20)), int'($urandom_range(1, 6)),
                 10'($urandom_range(0, 1023)), n);
        end

        // Reset mid-sequence.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_reset();
        chk("mrst_out", {22'b0, out_port}, 32'd0);
        chk("mrst_irq", {31'b0, irq}, 32'd0);
        for (int a = 0; a < 16; a++)
            rd(4'(a), 32'hFFFF_FFFF, (a == 2) ? 32'd1 : 32'd0, $sformatf("mrst_reg%0d", a));
        tick;
        chk("mrst_idle", {22'b0, out_port}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
